// File: rtl/cu_pkg.sv
//==== cu_pkg : opcode, state and ALU-op encodings for cu_multicycle ====
//==== Rev 1.0 ====
`default_nettype none

package cu_pkg;

  localparam logic [2:0] OPC_MV   = 3'b000;
  localparam logic [2:0] OPC_MVI  = 3'b001;
  localparam logic [2:0] OPC_ADD  = 3'b010;
  localparam logic [2:0] OPC_SUB  = 3'b011;
  localparam logic [2:0] OPC_MOVO = 3'b100;
  localparam logic [2:0] OPC_AND  = 3'b101;
  localparam logic [2:0] OPC_MVNZ = 3'b110;
  localparam logic [2:0] OPC_ILL  = 3'b111;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_AND = 2'b10;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_T1    = 2'd1,
    S_T2    = 2'd2,
    S_T3    = 2'd3
  } state_t;

  function automatic logic [1:0] alu_op_of(input logic [2:0] opc);
    case (opc)
      OPC_SUB: alu_op_of = ALU_OP_SUB;
      OPC_AND: alu_op_of = ALU_OP_AND;
      default: alu_op_of = ALU_OP_ADD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_dec.sv
//==== onehot_dec : binary index to one-hot decoder with enable ====
//==== Rev 1.0 ====
`default_nettype none

module onehot_dec #(
  parameter int W = 3
) (
  input  logic [W-1:0]      i_idx,
  input  logic              i_en,
  output logic [(1<<W)-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_idx] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/cu_multicycle.sv
//==== cu_multicycle : multi-cycle control unit for the register-file CPU ====
//==== Rev 1.0 ; optional trap on opcode 111 via CU_ILLEGAL_TRAP_EN ====
`default_nettype none

module cu_multicycle
  import cu_pkg::*;
#(
  parameter int NREG   = 8,
  parameter int RSEL_W = $clog2(NREG),
  parameter int IR_W   = 3 + 2*RSEL_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [IR_W-1:0] ir_in,
  input  logic            g_zero,
  output logic            ir_ena,
  output logic [NREG-1:0] rout_sel,
  output logic            din_sel,
  output logic            aluout_sel,
  output logic [NREG-1:0] reg_sel,
  output logic            alu_a_ena,
  output logic            alu_g_ena,
  output logic [1:0]      alu_op,
  output logic            out_ena,
  output logic            done,
  output logic            illegal
);

  state_t            r_state;
  state_t            w_next;
  logic [IR_W-1:0]   r_ir;
  logic [2:0]        w_opc;
  logic [RSEL_W-1:0] w_rx;
  logic [RSEL_W-1:0] w_ry;
  logic [NREG-1:0]   w_rx_oh;
  logic [NREG-1:0]   w_ry_oh;
  logic [NREG-1:0]   w_reg_sel;
  logic              w_ir_ena;
  logic              w_a_ena;
  logic              w_g_ena;
  logic              w_out_ena;
  logic              w_done;
  logic              w_trap;

  assign w_opc = r_ir[IR_W-1 -: 3];
  assign w_rx  = r_ir[2*RSEL_W-1 -: RSEL_W];
  assign w_ry  = r_ir[RSEL_W-1:0];

  onehot_dec #(.W(RSEL_W)) u_dec_rx (
    .i_idx    (w_rx),
    .i_en     (r_state != S_FETCH),
    .o_onehot (w_rx_oh)
  );

  onehot_dec #(.W(RSEL_W)) u_dec_ry (
    .i_idx    (w_ry),
    .i_en     (r_state != S_FETCH),
    .o_onehot (w_ry_oh)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && run) r_ir <= ir_in;
    end
  end

  always_comb begin
    w_next     = r_state;
    rout_sel   = '0;
    din_sel    = 1'b0;
    aluout_sel = 1'b0;
    alu_op     = ALU_OP_ADD;
    w_reg_sel  = '0;
    w_ir_ena   = 1'b0;
    w_a_ena    = 1'b0;
    w_g_ena    = 1'b0;
    w_out_ena  = 1'b0;
    w_done     = 1'b0;
    w_trap     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_ena = 1'b1;
        w_next   = S_T1;
      end
      S_T1: begin
        w_next = S_FETCH;
        case (w_opc)
          OPC_MV:   begin rout_sel = w_ry_oh; w_reg_sel = w_rx_oh; w_done = 1'b1; end
          OPC_MVI:  begin din_sel = 1'b1;     w_reg_sel = w_rx_oh; w_done = 1'b1; end
          OPC_MOVO: begin rout_sel = w_rx_oh; w_out_ena = 1'b1;    w_done = 1'b1; end
          OPC_MVNZ: begin
            rout_sel = w_ry_oh;
            w_done   = 1'b1;
            if (!g_zero) w_reg_sel = w_rx_oh;
          end
          OPC_ADD, OPC_SUB, OPC_AND: begin
            rout_sel = w_rx_oh;
            w_a_ena  = 1'b1;
            w_next   = S_T2;
          end
          default: begin
`ifdef CU_ILLEGAL_TRAP_EN
            // Parks in T1 until reset; only the sticky flag records why.
            w_trap = 1'b1;
            w_next = S_T1;
`else
            w_done = 1'b1;
`endif
          end
        endcase
      end
      S_T2: begin
        rout_sel = w_ry_oh;
        w_g_ena  = 1'b1;
        alu_op   = alu_op_of(w_opc);
        w_next   = S_T3;
      end
      S_T3: begin
        aluout_sel = 1'b1;
        w_reg_sel  = w_rx_oh;
        w_done     = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    if (!run) w_next = r_state;
  end

  // Strobes are gated by run so a stall can never repeat a write or load.
  assign ir_ena    = w_ir_ena & run;
  assign reg_sel   = run ? w_reg_sel : '0;
  assign alu_a_ena = w_a_ena & run;
  assign alu_g_ena = w_g_ena & run;
  assign out_ena   = w_out_ena & run;
  assign done      = w_done & run;

`ifdef CU_ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_illegal <= 1'b0;
    else if (w_trap && run) r_illegal <= 1'b1;
  end

  assign illegal = r_illegal;
`else
  assign illegal = w_trap;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cu_multicycle.sv
//==== tb_cu_multicycle : directed self-checking bench for cu_multicycle ====
//==== Rev 1.0 ====
`default_nettype none
`timescale 1ns/1ps

module tb_cu_multicycle;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       g_zero;
  logic [8:0] ir_in;
  logic       ir_ena, din_sel, aluout_sel, alu_a_ena, alu_g_ena, out_ena, done, illegal;
  logic [7:0] rout_sel, reg_sel;
  logic [1:0] alu_op;

  logic       run4;
  logic [6:0] ir_in4;
  logic       ir_ena4, din_sel4, aluout_sel4, alu_a_ena4, alu_g_ena4, out_ena4, done4, illegal4;
  logic [3:0] rout_sel4, reg_sel4;
  logic [1:0] alu_op4;

  int total = 0;
  int bad   = 0;

  logic [25:0] obs;
  logic [25:0] e;

  always #5 clk = ~clk;

  cu_multicycle u_dut (
    .clk(clk), .rst(rst), .run(run), .ir_in(ir_in), .g_zero(g_zero),
    .ir_ena(ir_ena), .rout_sel(rout_sel), .din_sel(din_sel), .aluout_sel(aluout_sel),
    .reg_sel(reg_sel), .alu_a_ena(alu_a_ena), .alu_g_ena(alu_g_ena), .alu_op(alu_op),
    .out_ena(out_ena), .done(done), .illegal(illegal)
  );

  cu_multicycle #(.NREG(4)) u_dut4 (
    .clk(clk), .rst(rst), .run(run4), .ir_in(ir_in4), .g_zero(1'b0),
    .ir_ena(ir_ena4), .rout_sel(rout_sel4), .din_sel(din_sel4), .aluout_sel(aluout_sel4),
    .reg_sel(reg_sel4), .alu_a_ena(alu_a_ena4), .alu_g_ena(alu_g_ena4), .alu_op(alu_op4),
    .out_ena(out_ena4), .done(done4), .illegal(illegal4)
  );

  assign obs = {ir_ena, rout_sel, din_sel, aluout_sel, reg_sel,
                alu_a_ena, alu_g_ena, alu_op, out_ena, done, illegal};

  function automatic logic [25:0] ev(input logic ir, input logic [7:0] rout, input logic din,
                                     input logic aluo, input logic [7:0] rg, input logic a,
                                     input logic g, input logic [1:0] op, input logic outp,
                                     input logic dn, input logic ill);
    return {ir, rout, din, aluo, rg, a, g, op, outp, dn, ill};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; g_zero = 1'b0; ir_in = '0; run4 = 1'b0; ir_in4 = '0;
    cyc();
    @(negedge clk);
    e = ev(1, 8'h00, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL reset_hold got=%h exp=%h", obs, e); end
    cyc();
    rst = 1'b0; run = 1'b0;
    @(negedge clk);
    e = '0;
    total++; if (obs !== e) begin bad++; $display("FAIL reset_release got=%h exp=%h", obs, e); end
  endtask

  task automatic test_reset_midinst();
    cyc(); run = 1'b1; ir_in = 9'b010_001_010;
    @(negedge clk);
    e = ev(1, 8'h00, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL abort_fetch got=%h exp=%h", obs, e); end
    cyc(); @(negedge clk);
    e = ev(0, 8'h02, 0, 0, 8'h00, 1, 0, 2'b00, 0, 0, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL abort_t1 got=%h exp=%h", obs, e); end
    cyc(); @(negedge clk);
    e = ev(0, 8'h04, 0, 0, 8'h00, 0, 1, 2'b00, 0, 0, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL abort_t2 got=%h exp=%h", obs, e); end
    #1 rst = 1'b1;
    #1;
    e = ev(1, 8'h00, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL abort_async got=%h exp=%h", obs, e); end
    cyc(); rst = 1'b0; run = 1'b0; ir_in = '0;
    @(negedge clk);
    e = '0;
    total++; if (obs !== e) begin bad++; $display("FAIL abort_release got=%h exp=%h", obs, e); end
    cyc(); @(negedge clk);
    total++; if (obs !== e) begin bad++; $display("FAIL abort_nowrite got=%h exp=%h", obs, e); end
  endtask

  task automatic test_mvi();
    cyc(); run = 1'b1; ir_in = 9'b001_101_000;
    @(negedge clk);
    e = ev(1, 8'h00, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL mvi_fetch got=%h exp=%h", obs, e); end
    cyc(); @(negedge clk);
    e = ev(0, 8'h00, 1, 0, 8'h20, 0, 0, 2'b00, 0, 1, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL mvi_t1 got=%h exp=%h", obs, e); end
  endtask

  task automatic test_mv_movo();
    cyc(); ir_in = 9'b000_111_010;
    @(negedge clk);
    e = ev(1, 8'h00, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL mv_fetch got=%h exp=%h", obs, e); end
    cyc(); @(negedge clk);
    e = ev(0, 8'h04, 0, 0, 8'h80, 0, 0, 2'b00, 0, 1, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL mv_t1 got=%h exp=%h", obs, e); end
    cyc(); ir_in = 9'b100_110_000;
    @(negedge clk);
    cyc(); @(negedge clk);
    e = ev(0, 8'h40, 0, 0, 8'h00, 0, 0, 2'b00, 1, 1, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL movo_t1 got=%h exp=%h", obs, e); end
  endtask

  task automatic test_alu(input logic [8:0] ins, input logic [7:0] rx, input logic [7:0] ry,
                          input logic [1:0] op);
    cyc(); ir_in = ins;
    @(negedge clk);
    e = ev(1, 8'h00, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL alu_fetch ins=%b got=%h exp=%h", ins, obs, e); end
    cyc(); @(negedge clk);
    e = ev(0, rx, 0, 0, 8'h00, 1, 0, 2'b00, 0, 0, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL alu_t1 ins=%b got=%h exp=%h", ins, obs, e); end
    cyc(); @(negedge clk);
    e = ev(0, ry, 0, 0, 8'h00, 0, 1, op, 0, 0, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL alu_t2 ins=%b got=%h exp=%h", ins, obs, e); end
    cyc(); @(negedge clk);
    e = ev(0, 8'h00, 0, 1, rx, 0, 0, 2'b00, 0, 1, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL alu_t3 ins=%b got=%h exp=%h", ins, obs, e); end
  endtask

  task automatic test_stall();
    cyc(); ir_in = 9'b010_001_001;
    @(negedge clk);
    cyc(); @(negedge clk);
    e = ev(0, 8'h02, 0, 0, 8'h00, 1, 0, 2'b00, 0, 0, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL stall_t1 got=%h exp=%h", obs, e); end
    for (int i = 0; i < 3; i++) begin
      cyc(); run = 1'b0;
      @(negedge clk);
      e = ev(0, 8'h02, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0);
      total++; if (obs !== e) begin bad++; $display("FAIL stall_hold%0d got=%h exp=%h", i, obs, e); end
    end
    cyc(); run = 1'b1;
    @(negedge clk);
    e = ev(0, 8'h02, 0, 0, 8'h00, 0, 1, 2'b00, 0, 0, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL stall_resume_t2 got=%h exp=%h", obs, e); end
    cyc(); @(negedge clk);
    e = ev(0, 8'h00, 0, 1, 8'h02, 0, 0, 2'b00, 0, 1, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL stall_t3 got=%h exp=%h", obs, e); end
  endtask

  task automatic test_mvnz();
    cyc(); ir_in = 9'b110_100_000; g_zero = 1'b1;
    @(negedge clk);
    cyc(); @(negedge clk);
    e = ev(0, 8'h01, 0, 0, 8'h00, 0, 0, 2'b00, 0, 1, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL mvnz_zero got=%h exp=%h", obs, e); end
    cyc(); g_zero = 1'b0;
    @(negedge clk);
    cyc(); @(negedge clk);
    e = ev(0, 8'h01, 0, 0, 8'h10, 0, 0, 2'b00, 0, 1, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL mvnz_nonzero got=%h exp=%h", obs, e); end
  endtask

  task automatic test_illegal();
    cyc(); ir_in = 9'b111_000_000;
    @(negedge clk);
    cyc(); @(negedge clk);
`ifdef CU_ILLEGAL_TRAP_EN
    e = '0;
    total++; if (obs !== e) begin bad++; $display("FAIL ill_t1 got=%h exp=%h", obs, e); end
    for (int i = 0; i < 2; i++) begin
      cyc(); @(negedge clk);
      e = ev(0, 8'h00, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 1);
      total++; if (obs !== e) begin bad++; $display("FAIL ill_sticky%0d got=%h exp=%h", i, obs, e); end
    end
`else
    e = ev(0, 8'h00, 0, 0, 8'h00, 0, 0, 2'b00, 0, 1, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL ill_nop got=%h exp=%h", obs, e); end
    cyc(); ir_in = '0;
    @(negedge clk);
    e = ev(1, 8'h00, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0);
    total++; if (obs !== e) begin bad++; $display("FAIL ill_next_fetch got=%h exp=%h", obs, e); end
`endif
    cyc(); rst = 1'b1; run = 1'b0;
    @(negedge clk);
    cyc(); rst = 1'b0;
    @(negedge clk);
    e = '0;
    total++; if (obs !== e) begin bad++; $display("FAIL ill_cleared got=%h exp=%h", obs, e); end
  endtask

  task automatic test_nreg4();
    cyc(); run4 = 1'b1; ir_in4 = 7'b000_11_00;
    @(negedge clk);
    total++; if (ir_ena4 !== 1'b1) begin bad++; $display("FAIL n4_fetch got=%b exp=1", ir_ena4); end
    cyc(); @(negedge clk);
    total++;
    if ({rout_sel4, reg_sel4, done4, din_sel4} !== {4'h1, 4'h8, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL n4_mv_t1 got rout=%h reg=%h done=%b exp rout=1 reg=8 done=1",
               rout_sel4, reg_sel4, done4);
    end
    cyc(); run4 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_reset_midinst();
    test_mvi();
    test_mv_movo();
    test_alu(9'b011_010_111, 8'h04, 8'h80, 2'b01);
    test_alu(9'b101_011_101, 8'h08, 8'h20, 2'b10);
    test_alu(9'b010_011_011, 8'h08, 8'h08, 2'b00);
    test_stall();
    test_mvnz();
    test_illegal();
    test_nreg4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
